rr_mux: RTL and testbench

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/rr_mux.sv | 128 ++++++++++++
 tb/tb_rr_mux.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin / fixed-select multiplexer.
//   MODE_FIXED / MODE_RR : values of the rr_mux mode input
//   N_MIN..N_MAX         : legal channel counts
//   W_MIN..W_MAX         : legal per-channel data widths
//   state_e              : output-stage state (empty / holding a word)
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 16;
  localparam int unsigned W_MIN = 1;
  localparam int unsigned W_MAX = 64;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search, purely combinational.
//   req         : request vector, one bit per channel
//   start       : channel index searched first; search wraps N-1 -> 0
//   grant_valid : at least one request was found
//   grant       : index of the first requesting channel at or after start
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic          grant_valid,
  output logic [SW-1:0] grant
);

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      // start is always < N in practice; the modulo also keeps idx legal otherwise
      idx = (32'(start) + i) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel multiplexer with a single registered output stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   ip         : channel data, channel k at bits [k*W +: W]
//   ip_valid   : channel k holds a word
//   ip_ready   : channel k word accepted this cycle (at most one bit set)
//   mode       : MODE_FIXED selects channel s, MODE_RR rotates from ptr
//   s          : channel index used in fixed mode (s >= N grants nothing)
//   op         : registered selected data
//   op_valid   : op holds a word
//   op_ready   : downstream accepts op this cycle
//   sel        : channel index that produced op
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 1,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  ip,
  input  logic [N-1:0]    ip_valid,
  output logic [N-1:0]    ip_ready,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  output logic [W-1:0]    op,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [SW-1:0]   sel
);

  state_e        state_q, state_d;
  logic [W-1:0]  op_q, op_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          s_in_range;
  logic          fix_valid;
  logic          rr_valid;
  logic [SW-1:0] rr_grant;
  logic          grant_valid;
  logic [SW-1:0] grant;
  logic [W-1:0]  word;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req         (ip_valid),
    .start       (ptr_q),
    .grant_valid (rr_valid),
    .grant       (rr_grant)
  );

  // The output register can take a new word when empty or when it is draining now.
  assign load       = (state_q == StEmpty) || op_ready;
  assign s_in_range = (32'(s) < N);
  assign fix_valid  = s_in_range && ip_valid[s];

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    // Gating with rst_n keeps ip_ready low for the whole reset, not just after an edge.
    if (rst_n && load) begin
      if (mode == MODE_RR) begin
        grant_valid = rr_valid;
        grant       = rr_grant;
      end else begin
        grant_valid = fix_valid;
        grant       = s;
      end
    end
  end

  always_comb begin
    ip_ready = '0;
    if (grant_valid) begin
      ip_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == SW'(k)) begin
        word = ip[k*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (grant_valid) begin
      state_d = StFull;
      op_d    = word;
      sel_d   = grant;
      if (mode == MODE_RR) begin
        ptr_d = (32'(grant) == N - 1) ? '0 : SW'(32'(grant) + 32'd1);
      end
    end else if ((state_q == StFull) && op_ready) begin
      // Word drained with nothing to replace it; op and sel keep their last values.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      op_q    <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign op       = op_q;
  assign sel      = sel_q;
  assign op_valid = (state_q == StFull);

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (N=4, W=8). A negedge monitor pushes every
// accepted input word into a scoreboard queue and pops/compares it when the
// output handshake completes; scenario tasks check grants and stage behaviour.
module tb_rr_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] k;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N*W-1:0]  ip;
  logic [N-1:0]    ip_valid;
  logic [N-1:0]    ip_ready;
  logic            mode;
  logic [SW-1:0]   s;
  logic [W-1:0]    op;
  logic            op_valid;
  logic            op_ready;
  logic [SW-1:0]   sel;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  rr_mux #(
    .N (N),
    .W (W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ip       (ip),
    .ip_valid (ip_valid),
    .ip_ready (ip_ready),
    .mode     (mode),
    .s        (s),
    .op       (op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .sel      (sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: compare the leaving word first, then record the arriving one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid && op_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: op=%h sel=%0d left, required no output", op, sel);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (op !== e.d || sel !== e.k) begin
            bad++;
            $display("FAIL sb_data: op=%h sel=%0d, required op=%h sel=%0d", op, sel, e.d, e.k);
          end
        end
      end
      total++;
      if ($countones(ip_ready) > 1) begin
        bad++;
        $display("FAIL ready_onehot: ip_ready=%b, required at most one bit", ip_ready);
      end
      for (int k = 0; k < N; k++) begin
        if (ip_valid[k] && ip_ready[k]) begin
          exp_t e;
          e.d = ip[k*W +: W];
          e.k = SW'(k);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ip_valid = '0;
    op_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    ip       = {8'h44, 8'h33, 8'h22, 8'h11};
    ip_valid = 4'b1111;
    mode     = 1'b1;
    s        = 2'd0;
    op_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (op_valid !== 1'b0) begin
      bad++; $display("FAIL reset_op_valid: got %b, required 0", op_valid);
    end
    total++;
    if (op !== 8'h00) begin
      bad++; $display("FAIL reset_op: got %h, required 00", op);
    end
    total++;
    if (sel !== 2'd0) begin
      bad++; $display("FAIL reset_sel: got %0d, required 0", sel);
    end
    total++;
    if (ip_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ip_ready: got %b, required 0000", ip_ready);
    end
    ip_valid = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fixed();
    mode     = 1'b0;
    s        = 2'd2;
    ip       = {8'h44, 8'hA5, 8'h22, 8'h11};
    ip_valid = 4'b1111;
    op_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ip_ready !== 4'b0100) begin
      bad++; $display("FAIL fixed_ready: got %b, required 0100", ip_ready);
    end
    step();
    ip_valid = '0;
    total++;
    if (op !== 8'hA5 || sel !== 2'd2 || op_valid !== 1'b1) begin
      bad++;
      $display("FAIL fixed_out: op=%h sel=%0d v=%b, required A5 2 1", op, sel, op_valid);
    end
    idle();
  endtask

  task automatic test_rr();
    mode     = 1'b1;
    ip       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    ip_valid = 4'b1111;
    op_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = 4'b0001 << (i % 4);
      @(negedge clk);
      total++;
      if (ip_ready !== exp_rdy) begin
        bad++; $display("FAIL rr_ready[%0d]: got %b, required %b", i, ip_ready, exp_rdy);
      end
      if (i > 0) begin
        total++;
        if (op_valid !== 1'b1 || sel !== SW'((i - 1) % 4)) begin
          bad++;
          $display("FAIL rr_sel[%0d]: sel=%0d v=%b, required %0d 1", i, sel, op_valid,
                   (i - 1) % 4);
        end
      end
      step();
    end
    ip_valid = '0;
    total++;
    if (sel !== 2'd3 || op_valid !== 1'b1) begin
      bad++; $display("FAIL rr_last: sel=%0d v=%b, required 3 1", sel, op_valid);
    end
    idle();
  endtask

  task automatic test_skip();
    mode     = 1'b1;
    ip       = {8'h93, 8'h92, 8'h91, 8'h90};
    ip_valid = 4'b0001;
    op_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ip_ready !== 4'b0001) begin
      bad++; $display("FAIL skip_prime: got %b, required 0001", ip_ready);
    end
    step();
    ip_valid = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = (j % 2 == 0) ? 4'b1000 : 4'b0001;
      @(negedge clk);
      total++;
      if (ip_ready !== exp_rdy) begin
        bad++; $display("FAIL skip_ready[%0d]: got %b, required %b", j, ip_ready, exp_rdy);
      end
      step();
    end
    idle();
  endtask

  task automatic test_stall();
    mode     = 1'b0;
    s        = 2'd1;
    ip       = {8'h00, 8'h00, 8'h3C, 8'h00};
    ip_valid = 4'b0010;
    op_ready = 1'b0;
    @(negedge clk);
    total++;
    if (ip_ready !== 4'b0010) begin
      bad++; $display("FAIL stall_first: got %b, required 0010", ip_ready);
    end
    step();
    ip[1*W +: W] = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (op !== 8'h3C || sel !== 2'd1 || ip_ready !== 4'b0000 || op_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: op=%h sel=%0d rdy=%b v=%b, required 3C 1 0000 1",
                 c, op, sel, ip_ready, op_valid);
      end
      step();
    end
    op_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ip_ready !== 4'b0010) begin
      bad++; $display("FAIL stall_reload: got %b, required 0010", ip_ready);
    end
    step();
    ip_valid = '0;
    total++;
    if (op !== 8'h5A || op_valid !== 1'b1) begin
      bad++; $display("FAIL stall_next: op=%h v=%b, required 5A 1", op, op_valid);
    end
    idle();
  endtask

  task automatic test_fixed_idle();
    mode     = 1'b0;
    s        = 2'd0;
    ip       = {8'h88, 8'h66, 8'h55, 8'h77};
    ip_valid = 4'b0001;
    op_ready = 1'b0;
    step();
    s        = 2'd2;
    ip_valid = 4'b1011;
    op_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ip_ready !== 4'b0000 || op_valid !== 1'b1) begin
      bad++; $display("FAIL fidle_ready: rdy=%b v=%b, required 0000 1", ip_ready, op_valid);
    end
    step();
    total++;
    if (op_valid !== 1'b0 || op !== 8'h77 || sel !== 2'd0) begin
      bad++;
      $display("FAIL fidle_drain: v=%b op=%h sel=%0d, required 0 77 0", op_valid, op, sel);
    end
    idle();
  endtask

  task automatic test_async_reset();
    mode     = 1'b1;
    ip       = {8'hF3, 8'hF2, 8'hF1, 8'hC3};
    ip_valid = 4'b0001;
    op_ready = 1'b0;
    step();
    ip_valid = 4'b1111;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (op_valid !== 1'b0 || op !== 8'h00 || sel !== 2'd0 || ip_ready !== 4'b0000) begin
      bad++;
      $display("FAIL areset: v=%b op=%h sel=%0d rdy=%b, required 0 00 0 0000",
               op_valid, op, sel, ip_ready);
    end
    sb.delete();
    step();
    rst_n    = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ip_ready !== 4'b0001) begin
      bad++; $display("FAIL areset_restart: got %b, required 0001", ip_ready);
    end
    step();
    ip_valid = '0;
    total++;
    if (sel !== 2'd0 || op !== 8'hC3 || op_valid !== 1'b1) begin
      bad++;
      $display("FAIL areset_first: sel=%0d op=%h v=%b, required 0 C3 1", sel, op, op_valid);
    end
    idle();
  endtask

  task automatic test_drain();
    idle();
    total++;
    if (sb.size() != 0 || op_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: pending=%0d v=%b, required 0 0", sb.size(), op_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_skip();
    test_stall();
    test_fixed_idle();
    test_async_reset();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
